// File: rtl/pdm_pkg.sv
// Shared PDM definitions used by the transmit modulator and the receive-side
// density counter: window geometry, density word type and source selection.
package pdm_pkg;

    localparam int PDM_WIN_LOG2 = 8;
    localparam int PDM_WIN_LEN  = 1 << PDM_WIN_LOG2;
    localparam int PDM_DW       = PDM_WIN_LOG2 + 1;

    // Density word: count of ones per window, legal range 0..PDM_WIN_LEN.
    typedef logic [PDM_DW-1:0] pdm_density_t;

    // Where the active density comes from at a window boundary.
    typedef enum logic [1:0] {
        SRC_REPEAT = 2'd0,
        SRC_HOLD   = 2'd1,
        SRC_BYPASS = 2'd2
    } cur_src_e;

    function automatic pdm_density_t pdm_saturate(input pdm_density_t d);
        return (d > pdm_density_t'(PDM_WIN_LEN)) ? pdm_density_t'(PDM_WIN_LEN) : d;
    endfunction

endpackage

// File: rtl/pdm_accum.sv
// First-order PDM accumulate/compare/subtract step: one output bit per call,
// emitting a one each time the running sum crosses the window length.
module pdm_accum
    import pdm_pkg::*;
#(
    parameter int WIN_LOG2 = PDM_WIN_LOG2
) (
    input  logic [WIN_LOG2:0] acc_in,
    input  logic [WIN_LOG2:0] density,
    output logic              pdm_bit,
    output logic [WIN_LOG2:0] acc_next
);

    localparam logic [WIN_LOG2:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

    // acc_in stays below WIN_LEN and density is at most WIN_LEN, so the sum
    // never exceeds 2*WIN_LEN-1 and fits in WIN_LOG2+1 bits.
    logic [WIN_LOG2:0] sum;

    // NOTE: combinational logic uses blocking '=' so later lines see the new value;
    // clocked state always uses non-blocking '<='.
    always_comb begin
        sum      = acc_in + density;
        pdm_bit  = (sum >= WIN_LEN);
        acc_next = pdm_bit ? (sum - WIN_LEN) : sum;
    end

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: turns density samples into a 1-bit stream carrying exactly
// that many ones per fixed window, with a one-deep sample buffer.
module pdm_tx
    import pdm_pkg::*;
#(
    parameter int WIN_LOG2 = PDM_WIN_LOG2,
    parameter int DW       = WIN_LOG2 + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          pdm_out,
    output logic          win_start,
    output logic          underrun
);

    localparam int            WIN_LEN  = 1 << WIN_LOG2;
    localparam logic [DW-1:0] MAX_DENS = DW'(WIN_LEN);

    logic [WIN_LOG2-1:0] wcnt;
    logic                win_first;
    logic                win_last;
    logic [DW-1:0]       cur;
    logic [DW-1:0]       hold;
    logic [DW-1:0]       s_sat;
    logic                hold_full;
    logic                under_pend;
    logic                accept;
    logic                to_hold;
    logic [WIN_LOG2:0]   acc;
    logic [WIN_LOG2:0]   acc_in;
    logic [WIN_LOG2:0]   acc_next;
    logic                pdm_bit;
    cur_src_e            cur_src;

    assign win_first = (wcnt == '0);
    assign win_last  = &wcnt;

    // The hold register drains on the last cycle, so a new sample fits then.
    assign s_ready = !hold_full || win_last;
    assign accept  = s_valid && s_ready;
    assign s_sat   = (s_data > MAX_DENS) ? MAX_DENS : s_data;
    assign acc_in  = win_first ? '0 : acc;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cur_src = SRC_REPEAT;
        if (win_last) begin
            if (hold_full) begin
                cur_src = SRC_HOLD;
            end else if (s_valid) begin
                cur_src = SRC_BYPASS;
            end
        end
    end

    // A bypassed sample goes straight to cur and never occupies the hold slot.
    assign to_hold = accept && (cur_src != SRC_BYPASS);

    pdm_accum #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .acc_in   (acc_in),
        .density  (cur[WIN_LOG2:0]),
        .pdm_bit  (pdm_bit),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt       <= '0;
            acc        <= '0;
            cur        <= '0;
            hold_full  <= 1'b0;
            under_pend <= 1'b1;
            pdm_out    <= 1'b0;
            win_start  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            wcnt      <= wcnt + 1'b1;
            acc       <= acc_next;
            pdm_out   <= pdm_bit;
            win_start <= win_first;
            underrun  <= win_first && under_pend;

            case (cur_src)
                SRC_HOLD:   cur <= hold;
                SRC_BYPASS: cur <= s_sat;
                default:    cur <= cur;
            endcase

            // The window after reset has no sample either, so it flags underrun.
            if (win_last) begin
                under_pend <= (cur_src == SRC_REPEAT);
            end

            if (to_hold) begin
                hold_full <= 1'b1;
            end else if (cur_src == SRC_HOLD) begin
                hold_full <= 1'b0;
            end
        end
    end

    // NOTE: pure data registers skip reset; hold_full alone says whether hold is valid.
    always_ff @(posedge clk) begin
        if (to_hold) begin
            hold <= s_sat;
        end
    end

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx: counts ones, win_start and underrun per window
// as a receive-side density counter would, and compares with hand-computed values.
module tb_pdm_tx;

    localparam int WIN = 256;

    typedef struct {
        int ones;
        int ws_cnt;
        int ws_first;
        int ur_cnt;
        int ur_first;
        int alt;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [8:0] s_data;
    logic       s_ready;
    logic       pdm_out;
    logic       win_start;
    logic       underrun;

    int   checks = 0;
    int   errors = 0;
    int   w_model = 0;
    bit   acc_valid = 1'b0;
    win_t cur_win;
    win_t wq[$];

    pdm_tx dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .pdm_out   (pdm_out),
        .win_start (win_start),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge and folded into
    // per-window statistics. Window outputs span model wcnt 1..255,0.
    task automatic tick();
        logic r;
        int   off;
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            w_model   = 0;
            acc_valid = 1'b0;
        end else begin
            w_model = (w_model + 1) % WIN;
            if (w_model == 1) begin
                if (acc_valid) wq.push_back(cur_win);
                cur_win   = '{default: 0};
                cur_win.alt = 1;
                acc_valid = 1'b1;
            end
            if (acc_valid) begin
                off = (w_model + WIN - 1) % WIN;
                cur_win.ones   += int'(pdm_out);
                cur_win.ws_cnt += int'(win_start);
                cur_win.ur_cnt += int'(underrun);
                if (off == 0) begin
                    cur_win.ws_first = int'(win_start);
                    cur_win.ur_first = int'(underrun);
                end
                if (pdm_out !== 1'((off % 2))) cur_win.alt = 0;
            end
        end
    endtask

    task automatic ticks_to(input int t);
        int guard = 0;
        while (w_model != t && guard < 600) begin
            tick();
            guard++;
        end
    endtask

    task automatic offer(input logic [8:0] d);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 600 && !got; i++) begin
            got = s_ready;
            tick();
        end
        s_valid = 1'b0;
        chk("offer_accepted", int'(got), 1);
    endtask

    task automatic check_win(input string tag, input int exp_ones, input int exp_ur, input int want_alt);
        win_t w;
        if (wq.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        w = wq.pop_front();
        chk({tag, "_ones"}, w.ones, exp_ones);
        chk({tag, "_ws_cnt"}, w.ws_cnt, 1);
        chk({tag, "_ws_first"}, w.ws_first, 1);
        chk({tag, "_ur_cnt"}, w.ur_cnt, exp_ur);
        if (exp_ur != 0) chk({tag, "_ur_first"}, w.ur_first, 1);
        if (want_alt != 0) chk({tag, "_alternating"}, w.alt, 1);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) tick();
        chk("rst_pdm_out", int'(pdm_out), 0);
        chk("rst_win_start", int'(win_start), 0);
        chk("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        chk("rst_release_ready", int'(s_ready), 1);

        // window 0 (cur=0, underrun); 128 buffered in hold for window 1
        ticks_to(10);
        chk("rdy_idle", int'(s_ready), 1);
        offer(9'd128);
        chk("rdy_hold_full", int'(s_ready), 0);
        ticks_to(255);
        chk("rdy_last_cycle", int'(s_ready), 1);
        tick();

        // windows 2..4: 0, 256, 300 (saturates to 256)
        ticks_to(20); offer(9'd0);   ticks_to(0);
        ticks_to(20); offer(9'd256); ticks_to(0);
        ticks_to(20); offer(9'd300); ticks_to(0);

        // back-to-back 10, 20, 30 offered mid-window 4
        ticks_to(50);
        s_valid = 1'b1;
        s_data  = 9'd10;
        chk("bb_ready_first", int'(s_ready), 1);
        tick();
        s_data = 9'd20;
        chk("bb_ready_low", int'(s_ready), 0);
        ticks_to(254);
        chk("bb_ready_low_254", int'(s_ready), 0);
        tick();
        chk("bb_ready_last", int'(s_ready), 1);
        tick();
        s_data = 9'd30;
        chk("bb_ready_low_w5", int'(s_ready), 0);
        ticks_to(255);
        chk("bb_ready_last_w5", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;

        // window 7 carries 30; 64 loaded for window 8, then two starved windows
        ticks_to(255); tick();
        ticks_to(100); offer(9'd64);
        ticks_to(0); tick();
        ticks_to(0); tick();
        ticks_to(0);

        // loopback densities 1, 127, 255 in windows 11..13
        ticks_to(30); offer(9'd1);   ticks_to(0);
        ticks_to(30); offer(9'd127); ticks_to(0);
        ticks_to(30); offer(9'd255); ticks_to(0);
        tick(); ticks_to(0);

        // window 14 repeats 255; reset at wcnt=100 with 200 sitting in hold
        ticks_to(50); offer(9'd200);
        ticks_to(100);
        chk("pre_rst_hold_full", int'(s_ready), 0);
        chk("pre_rst_pdm_out", int'(pdm_out), 1);
        rst = 1'b1;
        tick();
        chk("post_rst_pdm_out", int'(pdm_out), 0);
        chk("post_rst_win_start", int'(win_start), 0);
        chk("post_rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        chk("post_rst_ready", int'(s_ready), 1);
        tick(); ticks_to(0);
        tick(); ticks_to(0);
        tick(); ticks_to(1);

        chk("window_count", wq.size(), 16);
        check_win("w0_after_reset", 0, 1, 0);
        check_win("w1_d128", 128, 0, 1);
        check_win("w2_d0", 0, 0, 0);
        check_win("w3_d256", 256, 0, 0);
        check_win("w4_d300_sat", 256, 0, 0);
        check_win("w5_d10", 10, 0, 0);
        check_win("w6_d20", 20, 0, 0);
        check_win("w7_d30", 30, 0, 0);
        check_win("w8_d64", 64, 0, 0);
        check_win("w9_d64_repeat", 64, 1, 0);
        check_win("w10_d64_repeat", 64, 1, 0);
        check_win("w11_d1", 1, 0, 0);
        check_win("w12_d127", 127, 0, 0);
        check_win("w13_d255", 255, 0, 0);
        check_win("wr0_after_midrst", 0, 1, 0);
        check_win("wr1_hold_discarded", 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_tx.md
PDM_TX -- requirements
Module: pdm_tx

Interface
REQ-001 Parameter WIN_LOG2, default 8, log2 of window length in clk cycles (window = 256).
REQ-002 Parameter DW, default WIN_LOG2+1, density word width (range 0..2^WIN_LOG2).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  density sample offered.
REQ-006 s_data  input  DW  density: number of ones required in one window.
REQ-007 s_ready  output  1  sample accepted on a cycle with s_valid && s_ready.
REQ-008 pdm_out  output  1  registered 1-bit density stream for the LVDS/tx pin.
REQ-009 win_start  output  1  one-cycle pulse, coincident with first pdm_out bit of each window.
REQ-010 underrun  output  1  one-cycle pulse, window started with no new sample available.

Function
REQ-011 Window counter wcnt, WIN_LOG2 bits, increments every cycle and wraps 2^WIN_LOG2-1 -> 0; last cycle = wcnt all-ones.
REQ-012 Active density cur (DW bits) is constant for a whole window and changes only on the last cycle of a window.
REQ-013 s_data > 2^WIN_LOG2 is saturated to 2^WIN_LOG2 on acceptance.
REQ-014 One-entry holding register hold with flag hold_full.
REQ-015 s_ready = !hold_full, or last window cycle (hold drains that cycle).
REQ-016 Last window cycle with hold_full: cur <= hold; a sample accepted that same cycle goes into hold (hold_full stays 1), otherwise hold_full <= 0.
REQ-017 Last window cycle, hold empty, s_valid=1: cur <= s_data (bypass), hold stays empty.
REQ-018 Last window cycle, hold empty, s_valid=0: cur unchanged (repeat), underrun pulses with the next window's win_start.
REQ-019 Non-last cycle with accepted sample: hold <= sample, hold_full <= 1.
REQ-020 Accumulator acc, WIN_LOG2+1 bits, is forced to 0 for the first cycle of every window.
REQ-021 Per cycle: sum = acc + cur; if sum >= 2^WIN_LOG2 then bit=1, acc <= sum - 2^WIN_LOG2, else bit=0, acc <= sum.
REQ-022 pdm_out <= bit (one-cycle latency from wcnt); exactly cur ones per window, no carry across windows.
REQ-023 win_start and underrun are registered in the same stage as pdm_out.
REQ-024 cur=0 gives all zeros; cur=2^WIN_LOG2 gives all ones.

Reset
REQ-025 rst=1: wcnt=0, acc=0, cur=0, hold_full=0, pdm_out=0, win_start=0, underrun=0; s_ready=1 in the cycle rst is released.
REQ-026 Reset mid-window discards hold and cur; the first window after reset starts at wcnt=0 with cur=0.
REQ-027 First win_start is asserted one cycle after the first post-reset wcnt=0 cycle.

Structure
REQ-028 A shared package holds WIN_LOG2 default, window length constant and the density word type, shared with the receive-side digitizer/counter.
REQ-029 One sub-module, pdm_accum (accumulate/compare/subtract, REQ-021), is instantiated; all control stays in pdm_tx.

Verification
REQ-030 Load 128 before a window -> pdm_out over that window 0,1,0,1,... with exactly 128 ones, win_start once per 256 cycles.
REQ-031 Load 0, then 256, then 300 in successive windows -> 0 ones, 256 ones, 256 ones.
REQ-032 Offer 3 samples back-to-back (10, 20, 30) mid-window -> 10 to hold, s_ready low until last cycle, 20 accepted then; windows carry 10, 20, 30 ones in order, none lost.
REQ-033 One sample 64, then s_valid low for 2 windows -> two further windows with 64 ones each, underrun pulsing at both starts.
REQ-034 rst pulsed at wcnt=100 with hold_full=1 -> all outputs 0 next cycle, hold discarded, next window all zeros with underrun.
REQ-035 Loopback to the receive-side 256-cycle density counter -> recovered count equals the loaded value for 0, 1, 127, 255, 256.
